reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5, register index width; depth is 2**ADDRESS_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 32, register and port data width.
REQ-003 Parameter BYPASS, default 1, selects write-to-read forwarding on same-address collision.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 AD1  input  ADDRESS_WIDTH  read port 1 index; its data feeds ALUop1 downstream.
REQ-007 AD2  input  ADDRESS_WIDTH  read port 2 index; its data feeds the ALU operand-2 mux.
REQ-008 AD3  input  ADDRESS_WIDTH  write port index.
REQ-009 WE3  input  1  write enable for port 3.
REQ-010 WD3  input  DATA_WIDTH  write data, normally ALUOut or a load result.
REQ-011 RD1  output  DATA_WIDTH  read data port 1.
REQ-012 RD2  output  DATA_WIDTH  read data port 2.
REQ-013 a0  output  DATA_WIDTH  live contents of register 10 for top-level observation.

Function
REQ-014 Storage SHALL be 2**ADDRESS_WIDTH registers of DATA_WIDTH bits.
REQ-015 Reads SHALL be combinational: RD1 = reg[AD1], RD2 = reg[AD2], zero-cycle latency.
REQ-016 Write SHALL occur on rising clk when WE3=1 and rst=0: reg[AD3] <= WD3; visible on RD1/RD2/a0 after that edge.
REQ-017 Register 0 SHALL read as 0 at all times; writes with AD3=0 SHALL be discarded.
REQ-018 WE3=0 SHALL leave all registers unchanged regardless of AD3/WD3.
REQ-019 BYPASS=1: when WE3=1, AD3!=0 and AD3==AD1 (or AD2), RD1 (or RD2) SHALL return WD3 in the same cycle.
REQ-020 BYPASS=0: same collision SHALL return the pre-write stored value until the clock edge.
REQ-021 Bypass SHALL never apply when AD3=0; reads of register 0 still return 0.
REQ-022 a0 SHALL equal stored reg[10] (no bypass); it changes only on clock edges or reset.
REQ-023 AD1==AD2 SHALL return identical data on both ports, including under bypass.
REQ-024 No arithmetic on data; all data paths exactly DATA_WIDTH, no truncation or extension.

Reset
REQ-025 Asserting rst SHALL immediately, without a clock edge, clear every register to 0; RD1, RD2 and a0 SHALL then read 0 (bypass still forwards WD3 per REQ-019 while rst is high is NOT permitted: bypass SHALL be gated off during rst).
REQ-026 While rst=1 all writes SHALL be ignored; a write coincident with rst deassertion edge is not guaranteed and is not used.
REQ-027 First write SHALL be accepted on the first rising clk with rst=0.

Structure
REQ-028 ADDRESS_WIDTH/DATA_WIDTH defaults and the register-index constants (ZERO=0, A0=10) SHALL live in the shared cpu package, also used by the ALU.
REQ-029 Storage, write logic and read/bypass muxing SHALL be a single module; no sub-module is required.
REQ-030 Bypass SHALL be a generate-selected combinational mux controlled by BYPASS.

Verification
REQ-031 Reset then read all 32 indices on RD1/RD2 -> every value 0, a0=0.
REQ-032 WE3=1, AD3=5, WD3=0xDEADBEEF, clock; AD1=5 -> RD1=0xDEADBEEF; AD2=6 -> RD2=0.
REQ-033 WE3=1, AD3=0, WD3=0xFFFFFFFF, clock; AD1=0 -> RD1=0; during write cycle RD1=0 (no bypass on x0).
REQ-034 reg[7]=0x11, same cycle WE3=1, AD3=7, WD3=0x22, AD1=AD2=7 -> BYPASS=1: RD1=RD2=0x22 before edge; BYPASS=0: 0x11 before, 0x22 after.
REQ-035 Write AD3=10, WD3=0x0000002A -> a0 becomes 0x2A only after the edge; WE3=0 with WD3=0x99 -> a0 stays 0x2A.
REQ-036 Load reg[3]=0x55, assert rst mid-cycle (between edges) with WE3=1 -> RD1(AD1=3)=0 immediately, stays 0 through edges while rst=1.

Source files
------------

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared cpu datapath widths and architectural register indices
package reg_file_pkg;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int ZERO   = 0;
   localparam int A0     = 10;
endpackage

// File: rtl/reg_file.sv
// reg_file: 2**ADDRESS_WIDTH x DATA_WIDTH register file, two async reads, one write, optional forwarding
module reg_file
   import reg_file_pkg::*;
#(
   parameter int ADDRESS_WIDTH = ADDR_W,
   parameter int DATA_WIDTH    = DATA_W,
   parameter int BYPASS        = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ADDRESS_WIDTH-1:0] AD1,
   input  logic [ADDRESS_WIDTH-1:0] AD2,
   input  logic [ADDRESS_WIDTH-1:0] AD3,
   input  logic                     WE3,
   input  logic [DATA_WIDTH-1:0]    WD3,
   output logic [DATA_WIDTH-1:0]    RD1,
   output logic [DATA_WIDTH-1:0]    RD2,
   output logic [DATA_WIDTH-1:0]    a0
);
   localparam int DEPTH = 2 ** ADDRESS_WIDTH;
   localparam logic [ADDRESS_WIDTH-1:0] ZERO_IDX = ADDRESS_WIDTH'(ZERO);
   localparam logic [ADDRESS_WIDTH-1:0] A0_IDX   = ADDRESS_WIDTH'(A0);
   logic [DATA_WIDTH-1:0] r_regs [DEPTH];
   logic                  w_wr;
   // x0 is never written, so it stays at its reset value of zero forever
   assign w_wr = WE3 && !rst && AD3 != ZERO_IDX;
   // storage: async clear on reset, single write port otherwise
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
      else if (w_wr) r_regs[AD3] <= WD3;
   assign a0 = r_regs[A0_IDX];
   generate
      if (BYPASS != 0) begin : g_byp
         // w_wr already excludes x0 and reset, so forwarding never leaks into those cases
         assign RD1 = (w_wr && AD3 == AD1) ? WD3 : r_regs[AD1];
         assign RD2 = (w_wr && AD3 == AD2) ? WD3 : r_regs[AD2];
      end else begin : g_nobyp
         assign RD1 = r_regs[AD1];
         assign RD2 = r_regs[AD2];
      end
   endgenerate
endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: checks bypassing and non-bypassing register files against an array model
module tb_reg_file;
   logic        clk = 0, rst = 0, WE3 = 0;
   logic [4:0]  AD1 = 0, AD2 = 0, AD3 = 0;
   logic [31:0] WD3 = 0;
   logic [31:0] rd1_b, rd2_b, a0_b, rd1_n, rd2_n, a0_n;
   logic [31:0] mem [32];
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   reg_file #(.BYPASS(1)) u_byp (.clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .AD3(AD3),
      .WE3(WE3), .WD3(WD3), .RD1(rd1_b), .RD2(rd2_b), .a0(a0_b));
   reg_file #(.BYPASS(0)) u_nob (.clk(clk), .rst(rst), .AD1(AD1), .AD2(AD2), .AD3(AD3),
      .WE3(WE3), .WD3(WD3), .RD1(rd1_n), .RD2(rd2_n), .a0(a0_n));

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
      if (a == 0) return 32'h0;
      if (byp && WE3 && !rst && AD3 == a) return WD3;
      return mem[a];
   endfunction

   task automatic edge_commit();
      @(posedge clk);
      if (rst) foreach (mem[i]) mem[i] = 0;
      else if (WE3 && AD3 != 0) mem[AD3] = WD3;
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1;
      WE3 = 0;
      #2 foreach (mem[i]) mem[i] = 0;
      for (int i = 0; i < 32; i++) begin
         AD1 = 5'(i); AD2 = 5'(31 - i);
         #1;
         total += 2;
         if (rd1_b !== 0 || rd2_b !== 0) begin bad++; $display("FAIL reset_byp idx=%0d rd1=%h rd2=%h want 0", i, rd1_b, rd2_b); end
         if (rd1_n !== 0 || rd2_n !== 0) begin bad++; $display("FAIL reset_nob idx=%0d rd1=%h rd2=%h want 0", i, rd1_n, rd2_n); end
      end
      total++;
      if (a0_b !== 0 || a0_n !== 0) begin bad++; $display("FAIL reset_a0 got %h/%h want 0", a0_b, a0_n); end
      @(negedge clk) rst = 0;
   endtask

   task automatic test_write_read();
      WE3 = 1; AD3 = 5; WD3 = 32'hDEADBEEF; AD1 = 0; AD2 = 0;
      edge_commit();
      WE3 = 0; AD1 = 5; AD2 = 6;
      #1;
      total += 3;
      if (rd1_b !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd1_byp got %h want deadbeef", rd1_b); end
      if (rd1_n !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rd1_nob got %h want deadbeef", rd1_n); end
      if (rd2_b !== 0 || rd2_n !== 0) begin bad++; $display("FAIL wr_rd2 got %h/%h want 0", rd2_b, rd2_n); end
   endtask

   task automatic test_zero();
      WE3 = 1; AD3 = 0; WD3 = 32'hFFFFFFFF; AD1 = 0; AD2 = 0;
      #1;
      total++;
      if (rd1_b !== 0 || rd1_n !== 0) begin bad++; $display("FAIL x0_during got %h/%h want 0", rd1_b, rd1_n); end
      edge_commit();
      WE3 = 0;
      #1;
      total++;
      if (rd1_b !== 0 || rd2_n !== 0) begin bad++; $display("FAIL x0_after got %h/%h want 0", rd1_b, rd2_n); end
   endtask

   task automatic test_bypass();
      WE3 = 1; AD3 = 7; WD3 = 32'h11;
      edge_commit();
      WD3 = 32'h22; AD1 = 7; AD2 = 7;
      #1;
      total += 2;
      if (rd1_b !== 32'h22 || rd2_b !== 32'h22) begin bad++; $display("FAIL byp_before got %h/%h want 22", rd1_b, rd2_b); end
      if (rd1_n !== 32'h11 || rd2_n !== 32'h11) begin bad++; $display("FAIL nob_before got %h/%h want 11", rd1_n, rd2_n); end
      edge_commit();
      WE3 = 0;
      #1;
      total += 2;
      if (rd1_n !== 32'h22 || rd2_n !== 32'h22) begin bad++; $display("FAIL nob_after got %h/%h want 22", rd1_n, rd2_n); end
      if (rd1_b !== 32'h22 || rd2_b !== 32'h22) begin bad++; $display("FAIL byp_after got %h/%h want 22", rd1_b, rd2_b); end
   endtask

   task automatic test_a0();
      WE3 = 1; AD3 = 10; WD3 = 32'h2A; AD1 = 10;
      #1;
      total += 2;
      if (a0_b !== 0) begin bad++; $display("FAIL a0_before got %h want 0", a0_b); end
      if (rd1_b !== 32'h2A) begin bad++; $display("FAIL a0_rd1_byp got %h want 2a", rd1_b); end
      edge_commit();
      total++;
      if (a0_b !== 32'h2A || a0_n !== 32'h2A) begin bad++; $display("FAIL a0_after got %h/%h want 2a", a0_b, a0_n); end
      WE3 = 0; WD3 = 32'h99;
      edge_commit();
      total++;
      if (a0_b !== 32'h2A || a0_n !== 32'h2A) begin bad++; $display("FAIL a0_hold got %h/%h want 2a", a0_b, a0_n); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 300; n++) begin
         AD3 = 5'($urandom_range(0, 31));
         AD1 = ($urandom_range(0, 3) == 0) ? AD3 : 5'($urandom_range(0, 31));
         AD2 = ($urandom_range(0, 3) == 0) ? AD3 : 5'($urandom_range(0, 31));
         WE3 = 1'($urandom_range(0, 1));
         WD3 = $urandom;
         #1;
         total += 5;
         if (rd1_b !== exp_rd(AD1, 1)) begin bad++; $display("FAIL rnd_rd1_byp a=%0d got %h want %h", AD1, rd1_b, exp_rd(AD1, 1)); end
         if (rd2_b !== exp_rd(AD2, 1)) begin bad++; $display("FAIL rnd_rd2_byp a=%0d got %h want %h", AD2, rd2_b, exp_rd(AD2, 1)); end
         if (rd1_n !== exp_rd(AD1, 0)) begin bad++; $display("FAIL rnd_rd1_nob a=%0d got %h want %h", AD1, rd1_n, exp_rd(AD1, 0)); end
         if (rd2_n !== exp_rd(AD2, 0)) begin bad++; $display("FAIL rnd_rd2_nob a=%0d got %h want %h", AD2, rd2_n, exp_rd(AD2, 0)); end
         if (a0_b !== mem[10] || a0_n !== mem[10]) begin bad++; $display("FAIL rnd_a0 got %h/%h want %h", a0_b, a0_n, mem[10]); end
         edge_commit();
      end
      WE3 = 0;
   endtask

   task automatic test_reset_midcycle();
      WE3 = 1; AD3 = 3; WD3 = 32'h55;
      edge_commit();
      WD3 = 32'h77; AD1 = 3; AD2 = 3;
      #1;
      total++;
      if (rd1_n !== 32'h55) begin bad++; $display("FAIL mid_load got %h want 55", rd1_n); end
      #1 rst = 1;
      #1;
      total += 2;
      if (rd1_b !== 0 || rd1_n !== 0 || rd2_b !== 0) begin bad++; $display("FAIL mid_rst_rd got %h/%h/%h want 0", rd1_b, rd1_n, rd2_b); end
      if (a0_b !== 0 || a0_n !== 0) begin bad++; $display("FAIL mid_rst_a0 got %h/%h want 0", a0_b, a0_n); end
      for (int k = 0; k < 2; k++) begin
         edge_commit();
         total++;
         if (rd1_b !== 0 || rd1_n !== 0) begin bad++; $display("FAIL rst_hold edge=%0d got %h/%h want 0", k, rd1_b, rd1_n); end
      end
      foreach (mem[i]) mem[i] = 0;
      @(negedge clk) rst = 0;
      WD3 = 32'hA5;
      edge_commit();
      WE3 = 0;
      #1;
      total++;
      if (rd1_b !== 32'hA5 || rd1_n !== 32'hA5) begin bad++; $display("FAIL first_write got %h/%h want a5", rd1_b, rd1_n); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_zero();
      test_bypass();
      test_a0();
      test_random();
      test_reset_midcycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
